// File: rtl/median_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 median window controller.
package median_window_ctrl_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_N = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/median_line_buf.sv
// Single-port line buffer: asynchronous read of the addressed entry, so a
// write in the same cycle still returns the old contents.
module median_line_buf
    import median_window_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Write port; storage is never reset, readers gate it with valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/median_window_ctrl.sv
// Streams a raster frame through two line buffers, builds 3x3 windows for
// the external median core and emits the interior filtered pixels.
module median_window_ctrl
    import median_window_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    input  logic [PIX_W-1:0] median_in,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t           state;
    state_t           state_next;
    logic             drain;
    logic             take;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb0_q;
    logic [PIX_W-1:0] lb1_q;
    logic [PIX_W-1:0] win [WIN_N];
    logic             win_v;

    assign take = in_valid && ((state == FILL) || (state == RUN));

    // State register plus the one-cycle drain marker used while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            drain <= 1'b0;
        end else begin
            state <= state_next;
            drain <= (state == DONE) && !drain;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (take && (row == RW'(1)) && (col == COL_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (take && (row == ROW_LAST) && (col == COL_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Second DONE cycle coincides with the last out_valid.
                if (drain) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster position of the next pixel; held at zero while idle.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    median_line_buf #(.DEPTH(IMG_W)) u_lb0 (
        .clk   (clk),
        .we    (take),
        .addr  (col),
        .wdata (in_pixel),
        .rdata (lb0_q)
    );

    median_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .we    (take),
        .addr  (col),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    // Window shifts left on each accept; new right column is rows r-2, r-1, r.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIN_N; i++) begin
                win[i] <= '0;
            end
        end else if (take) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[2] <= lb1_q;
            win[5] <= lb0_q;
            win[8] <= in_pixel;
        end
    end

    // Window-valid and its one-stage delay matching the core latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_v     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            win_v     <= take && (row >= RW'(2)) && (col >= CW'(2));
            out_valid <= win_v;
        end
    end

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

    assign out_pixel = median_in;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Randomized self-checking bench: a 5x5 instance and a 3x3 instance, each
// with a behavioural sorting core, checked against image-level medians.
module tb_median_window_ctrl;

    localparam int AW = 5;
    localparam int AH = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j] < s[j-1]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        return s[4];
    endfunction

    // ---------------- 5x5 instance ----------------
    logic       start_a = 1'b0, in_valid_a = 1'b0;
    logic [7:0] in_pixel_a = '0;
    logic       in_ready_a, out_valid_a, frame_done_a, busy_a;
    logic [7:0] pa0, pa1, pa2, pa3, pa4, pa5, pa6, pa7, pa8;
    logic [7:0] med_a = '0;
    logic [7:0] out_pixel_a;
    logic [7:0] wa [9];

    median_window_ctrl #(.IMG_W(AW), .IMG_H(AH)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_pixel(in_pixel_a),
        .in_ready(in_ready_a),
        .p0(pa0), .p1(pa1), .p2(pa2), .p3(pa3), .p4(pa4), .p5(pa5), .p6(pa6), .p7(pa7), .p8(pa8),
        .median_in(med_a), .out_valid(out_valid_a), .out_pixel(out_pixel_a),
        .frame_done(frame_done_a), .busy(busy_a)
    );

    always_comb begin
        wa[0] = pa0; wa[1] = pa1; wa[2] = pa2;
        wa[3] = pa3; wa[4] = pa4; wa[5] = pa5;
        wa[6] = pa6; wa[7] = pa7; wa[8] = pa8;
    end

    always @(posedge clk) med_a <= med9(wa);

    // ---------------- 3x3 instance ----------------
    logic       start_b = 1'b0, in_valid_b = 1'b0;
    logic [7:0] in_pixel_b = '0;
    logic       in_ready_b, out_valid_b, frame_done_b, busy_b;
    logic [7:0] pb0, pb1, pb2, pb3, pb4, pb5, pb6, pb7, pb8;
    logic [7:0] med_b = '0;
    logic [7:0] out_pixel_b;
    logic [7:0] wb [9];

    median_window_ctrl #(.IMG_W(3), .IMG_H(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_pixel(in_pixel_b),
        .in_ready(in_ready_b),
        .p0(pb0), .p1(pb1), .p2(pb2), .p3(pb3), .p4(pb4), .p5(pb5), .p6(pb6), .p7(pb7), .p8(pb8),
        .median_in(med_b), .out_valid(out_valid_b), .out_pixel(out_pixel_b),
        .frame_done(frame_done_b), .busy(busy_b)
    );

    always_comb begin
        wb[0] = pb0; wb[1] = pb1; wb[2] = pb2;
        wb[3] = pb3; wb[4] = pb4; wb[5] = pb5;
        wb[6] = pb6; wb[7] = pb7; wb[8] = pb8;
    end

    always @(posedge clk) med_b <= med9(wb);

    // ---------------- reference state ----------------
    logic [7:0] img_a [AW*AH];
    logic [7:0] img_b [9];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    bit act_a = 1'b0, act_b = 1'b0;   // frame expected to be accepting pixels
    bit int_a = 1'b0;                 // pixel being driven completes an interior window
    bit pv0 = 1'b0, pv1 = 1'b0;       // expected out_valid, one and two cycles ahead
    int n_out_a = 0;
    int n_out_b = 0;

    function automatic logic [7:0] ref_med_a(input int r, input int c);
        logic [7:0] v [9];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v[dr*3 + dc] = img_a[(r - 1 + dr)*AW + (c - 1 + dc)];
        return med9(v);
    endfunction

    // Monitor for the 5x5 instance.
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0;
            pv1 = 1'b0;
        end else begin
            check_eq("a_in_ready", in_ready_a, act_a);
            check_eq("a_busy", busy_a, act_a);
            check_eq("a_out_valid", out_valid_a, pv1);
            if (out_valid_a) begin
                check_eq("a_exp_avail", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) begin
                    check_eq("a_out_pixel", out_pixel_a, exp_a.pop_front());
                    check_eq("a_frame_done", frame_done_a, exp_a.size() == 0);
                end
                n_out_a++;
            end else begin
                check_eq("a_frame_done_idle", frame_done_a, 0);
            end
            pv1 = pv0;
            pv0 = in_valid_a && act_a && int_a;
        end
    end

    // Monitor for the 3x3 instance: every output is the last of its frame.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("b_in_ready", in_ready_b, act_b);
            if (out_valid_b) begin
                check_eq("b_exp_avail", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) check_eq("b_out_pixel", out_pixel_b, exp_b.pop_front());
                check_eq("b_frame_done", frame_done_b, 1);
                n_out_b++;
            end else begin
                check_eq("b_frame_done_idle", frame_done_b, 0);
            end
        end
    end

    // gap_mode: 0 continuous, 1 idle after every pixel, 2 random idles.
    // stop_after >= 0 resets the design right after that pixel is accepted.
    task automatic run_frame_a(input int gap_mode, input int stop_after, input int start_at);
        int n0;
        bit got;
        n0 = n_out_a;
        for (int r = 1; r < AH - 1; r++)
            for (int c = 1; c < AW - 1; c++)
                exp_a.push_back(ref_med_a(r, c));
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        act_a   = 1'b1;
        for (int k = 0; k < AW*AH; k++) begin
            in_valid_a = 1'b1;
            in_pixel_a = img_a[k];
            int_a      = ((k / AW) >= 2) && ((k % AW) >= 2);
            start_a    = (k == start_at);
            @(posedge clk); #1;
            start_a    = 1'b0;
            in_valid_a = 1'b0;
            int_a      = 1'b0;
            in_pixel_a = 8'($urandom);
            if (k == AW*AH - 1) act_a = 1'b0;
            if (k == stop_after) begin
                rst   = 1'b1;
                act_a = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_a.delete();
                return;
            end
            if (k != AW*AH - 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
                @(posedge clk); #1;
            end
        end
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_done_a) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("a_frame_done_seen", got, 1);
        @(posedge clk); #1;
        check_eq("a_frame_out_count", n_out_a - n0, (AW - 2)*(AH - 2));
        check_eq("a_exp_drained", exp_a.size(), 0);
    endtask

    task automatic run_frame_b();
        bit got;
        exp_b.push_back(med9(img_b));
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        act_b   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid_b = 1'b1;
            in_pixel_b = img_b[k];
            @(posedge clk); #1;
            in_valid_b = 1'b0;
            if (k == 8) act_b = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_done_b) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("b_frame_done_seen", got, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_out_valid", out_valid_a, 0);
        check_eq("rst_frame_done", frame_done_a, 0);
        check_eq("rst_passthru", out_pixel_a, med_a);
        for (int i = 0; i < 9; i++) check_eq("rst_window", wa[i], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp 0..24, continuous.
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'(k);
        run_frame_a(0, -1, -1);

        // Salt noise on the centre pixel.
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'd100;
        img_a[2*AW + 2] = 8'd255;
        run_frame_a(0, -1, -1);

        // Random data, alternating idle cycles.
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'($urandom);
        run_frame_a(1, -1, -1);

        // in_valid high while idle must be ignored.
        in_valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_pixel_a = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        @(posedge clk); #1;

        // Random data with a stray start during RUN.
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'($urandom);
        run_frame_a(0, -1, 15);

        // Reset after pixel 13, then a clean ramp frame.
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'($urandom);
        run_frame_a(0, 13, -1);
        @(posedge clk); #1;
        for (int k = 0; k < AW*AH; k++) img_a[k] = 8'(k);
        run_frame_a(0, -1, -1);

        // Random data, random idle cycles.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < AW*AH; k++) img_a[k] = 8'($urandom);
            run_frame_a(2, -1, -1);
        end

        // Two back-to-back 3x3 frames.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 9; k++) img_b[k] = 8'($urandom);
            run_frame_b();
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("b_out_count", n_out_b, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
